// File: rtl/sdr_qsram_pkg.sv
// Shared types and helpers for the SDR QSRAM request controller.
// Holds the FSM state encoding and a counter-width helper.
package sdr_qsram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        REFRESH = 2'd3
    } state_e;

    // Bits needed to hold count values 0..n-1 (at least 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdr_qsram_refresh_timer.sv
// Free-running refresh timer with sticky overrun detection.
// Ports: clk_i/rst_i, clr_i (refresh taken), pending_o, overrun_o.
module sdr_qsram_refresh_timer
    import sdr_qsram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic pending_o,
    output logic overrun_o
);

    localparam int CW = cnt_width(REFRESH_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == LAST);
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        // A new period's request wins over the clear of the old one.
        pend_d = wrap | (pend_q & ~clr_i);
        // Only an overrun if the old request is not being taken now.
        ovr_d  = ovr_q | (wrap & pend_q & ~clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pending_o = pend_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sdr_qsram_ctrl.sv
// Request-side controller for the SDR QSRAM array: sequences single-beat
// reads/writes and periodic refreshes onto the array pins.
// Ports: Req* handshake in, Rsp* read-data pulse out, Mem* array pins,
// RefreshOverrun sticky status.
module sdr_qsram_ctrl
    import sdr_qsram_pkg::*;
#(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0] ReqWData,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] RspData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemEnable,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  MemRefresh,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    output logic                  MemDataOE,
    input  logic [DATA_WIDTH-1:0] MemDataIn,
    output logic                  RefreshOverrun
);

    localparam int MAXC = (READ_LATENCY > REFRESH_CYCLES) ?
                          READ_LATENCY : REFRESH_CYCLES;
    localparam int CCW  = cnt_width(MAXC);
    localparam logic [CCW-1:0] RD_LAST = CCW'(READ_LATENCY - 1);
    localparam logic [CCW-1:0] RF_LAST = CCW'(REFRESH_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CCW-1:0]        cyc_q, cyc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  mem_rf_q, mem_rf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  pending;
    logic                  refresh_clr;

    sdr_qsram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_timer (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .clr_i    (refresh_clr),
        .pending_o(pending),
        .overrun_o(RefreshOverrun)
    );

    assign ReqReady = (state_q == IDLE) && !pending;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q + CCW'(1);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        refresh_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (pending) begin
                    state_d     = REFRESH;
                    refresh_clr = 1'b1;
                end else if (ReqValid) begin
                    addr_d  = ReqAddr;
                    wdata_d = ReqWData;
                    state_d = ReqWrite ? WRITE : READ;
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                if (cyc_q == RD_LAST) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MemDataIn;
                end
            end
            REFRESH: begin
                if (cyc_q == RF_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from the next state so they are glitch-free
        // and line up with the state they describe.
        mem_en_d   = (state_d != IDLE);
        mem_rd_d   = (state_d == READ);
        mem_wr_d   = (state_d == WRITE);
        mem_rf_d   = (state_d == REFRESH);
        mem_addr_d = (mem_rd_d || mem_wr_d) ? addr_d : '0;
        dout_d     = mem_wr_d ? wdata_d : '0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rf_q    <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_en_q    <= mem_en_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_rf_q    <= mem_rf_d;
            dout_q      <= dout_d;
        end
    end

    assign RspValid   = rsp_valid_q;
    assign RspData    = rsp_data_q;
    assign MemAddress = mem_addr_q;
    assign MemEnable  = mem_en_q;
    assign MemRead    = mem_rd_q;
    assign MemWrite   = mem_wr_q;
    assign MemRefresh = mem_rf_q;
    assign MemDataOut = dout_q;
    assign MemDataOE  = mem_wr_q;

endmodule

// File: tb/tb_sdr_qsram_ctrl.sv
// Scoreboard bench for sdr_qsram_ctrl: directed requests push expected
// pin/response items, a negedge monitor pops and compares them.
module tb_sdr_qsram_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       ReqValid, ReqReady, ReqWrite;
    logic [3:0] ReqAddr;
    logic [7:0] ReqWData;
    logic       RspValid;
    logic [7:0] RspData;
    logic [3:0] MemAddress;
    logic       MemEnable, MemRead, MemWrite, MemRefresh, MemDataOE;
    logic [7:0] MemDataOut, MemDataIn;
    logic       RefreshOverrun;

    sdr_qsram_ctrl dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspData(RspData),
        .MemAddress(MemAddress), .MemEnable(MemEnable),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemRefresh(MemRefresh),
        .MemDataOut(MemDataOut), .MemDataOE(MemDataOE),
        .MemDataIn(MemDataIn), .RefreshOverrun(RefreshOverrun)
    );

    always #5 Clock = ~Clock;

    // Array model: read data is {addr,addr} ^ 8'h69 while a read is on.
    assign MemDataIn = (MemRead && MemEnable) ?
                       ({MemAddress, MemAddress} ^ 8'h69) : 8'hEE;

    // Hand-computed values of the array model per address.
    logic [7:0] exp_tab [16] = '{
        8'h69, 8'h78, 8'h4B, 8'h5A, 8'h2D, 8'h3C, 8'h0F, 8'h1E,
        8'hE1, 8'hF0, 8'hC3, 8'hD2, 8'hA5, 8'hB4, 8'h87, 8'h96
    };

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         t;
    } item_t;

    item_t wq[$];
    item_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rf_seen = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Present a request (called at a negedge); returns the cycle tag of
    // the transfer cycle, or -1 if the controller never became ready.
    task automatic req(input logic w, input logic [3:0] a,
                       input logic [7:0] d, output int t);
        int n;
        item_t it;
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqAddr  = a;
        ReqWData = d;
        n = 0;
        while (!ReqReady && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (!ReqReady) begin
            fail("req_timeout");
            t = -1;
            return;
        end
        t    = cyc;
        it.a = a;
        it.d = w ? d : exp_tab[a];
        it.t = cyc;
        if (w) wq.push_back(it);
        else   rq.push_back(it);
        @(negedge Clock);
    endtask

    logic       prev_wr = 1'b0;
    logic       have_last = 1'b0;
    logic [7:0] last_rsp = 8'h00;
    int         rd_run = 0;

    always @(negedge Clock) begin
        item_t it;
        if (Reset) begin
            prev_wr   = 1'b0;
            have_last = 1'b0;
            rd_run    = 0;
        end else begin
            if (MemRead || MemWrite || MemRefresh) begin
                chk("excl", 32'(MemRead) + 32'(MemWrite) + 32'(MemRefresh),
                    32'd1);
                chk("enable", 32'(MemEnable), 32'd1);
            end
            if (MemWrite) begin
                chk("wr_1cyc", 32'(prev_wr), 32'd0);
                chk("wr_ready", 32'(ReqReady), 32'd0);
                chk("wr_oe", 32'(MemDataOE), 32'd1);
                if (wq.size() == 0) begin
                    fail("wr_unexpected");
                end else begin
                    it = wq.pop_front();
                    chk("wr_addr", 32'(MemAddress), 32'(it.a));
                    chk("wr_data", 32'(MemDataOut), 32'(it.d));
                end
            end else if (MemDataOE) begin
                fail("oe_stray");
            end
            if (MemRead) begin
                rd_run++;
                if (rq.size() > 0)
                    chk("rd_addr", 32'(MemAddress), 32'(rq[0].a));
            end else if (rd_run != 0) begin
                chk("rd_len", 32'(rd_run), 32'd2);
                rd_run = 0;
            end
            if (RspValid) begin
                if (rq.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    it = rq.pop_front();
                    chk("rsp_data", 32'(RspData), 32'(it.d));
                    chk("rsp_lat", 32'(cyc - it.t), 32'd3);
                end
                last_rsp  = RspData;
                have_last = 1'b1;
            end else if (have_last) begin
                chk("rsp_hold", 32'(RspData), 32'(last_rsp));
            end
            if (MemRefresh) rf_seen++;
            prev_wr = MemWrite;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        int rf0;
        int n;
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqAddr  = '0;
        ReqWData = '0;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("rst_outs",
            32'({MemEnable, MemRead, MemWrite, MemRefresh, MemDataOE,
                 RspValid, RefreshOverrun, MemAddress, MemDataOut,
                 RspData}), 32'd0);
        chk("rst_ready", 32'(ReqReady), 32'd1);

        // Idle refresh: wrap at edge 64, refresh during edges 65..66.
        for (int i = 1; i <= 67; i++) begin
            @(negedge Clock);
            if (i >= 63) begin
                chk("rf_ready", 32'(ReqReady),
                    32'(!(i >= 64 && i <= 66)));
                chk("rf_pin", 32'(MemRefresh),
                    32'(i == 65 || i == 66));
            end
        end

        req(1'b1, 4'h3, 8'hA5, t0);
        req(1'b0, 4'h3, 8'h00, t0);
        req(1'b1, 4'hF, 8'h3C, t0);
        req(1'b0, 4'h0, 8'h00, t0);
        req(1'b0, 4'hF, 8'h00, t0);

        req(1'b1, 4'h1, 8'h11, t0);
        req(1'b1, 4'h2, 8'h22, t1);
        chk("wr_spacing", 32'(t1 - t0), 32'd2);
        req(1'b0, 4'h2, 8'h00, t0);
        req(1'b0, 4'h7, 8'h00, t1);
        chk("rd_spacing", 32'(t1 - t0), 32'd3);

        // ReqValid held high across a timer wrap.
        rf0 = rf_seen;
        for (int k = 0; k < 30; k++)
            req(k[0], 4'(k), 8'(k * 7 + 1), t0);
        ReqValid = 1'b0;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk("drain", 32'(rq.size() + wq.size()), 32'd0);
        chk("rf_during_load", 32'(rf_seen - rf0), 32'd2);
        chk("no_overrun", 32'(RefreshOverrun), 32'd0);

        // Reset in the middle of a read.
        @(negedge Clock);
        req(1'b0, 4'h5, 8'h00, t0);
        ReqValid = 1'b0;
        chk("mid_rd_active", 32'(MemRead), 32'd1);
        #2;
        Reset = 1'b1;
        rq.delete();
        wq.delete();
        #1;
        chk("rst_async_en", 32'(MemEnable), 32'd0);
        chk("rst_async_rd", 32'(MemRead), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("rst_no_rsp", 32'(RspValid), 32'd0);
        end
        chk("rst_overrun", 32'(RefreshOverrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdr_qsram_ctrl.md
Name: sdr_qsram_ctrl

Overview:
Request-side controller that sits directly upstream of the single-data-rate QSRAM array and drives its Address/Enable/Read/Write/Refresh pins and data bus.
- Accepts single-beat read/write requests over a valid/ready handshake and sequences them onto the array.
- Inserts periodic refresh cycles with priority over requests.
- Returns read data on a one-cycle response pulse.

Parameters:
ADDR_WIDTH, 4, array address width
DATA_WIDTH, 8, data word width
READ_LATENCY, 2, cycles MemRead is held before MemDataIn is sampled (>=1)
REFRESH_INTERVAL, 64, cycles between refresh requests (>=REFRESH_CYCLES+4)
REFRESH_CYCLES, 2, cycles MemRefresh is held per refresh (>=1)

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high
ReqValid  input  1  request present
ReqReady  output  1  controller can accept
ReqWrite  input  1  1=write, 0=read
ReqAddr  input  ADDR_WIDTH  request address
ReqWData  input  DATA_WIDTH  write data
RspValid  output  1  one-cycle read-data pulse
RspData  output  DATA_WIDTH  read data, valid with RspValid
MemAddress  output  ADDR_WIDTH  to array Address
MemEnable  output  1  to array Enable
MemRead  output  1  to array Read
MemWrite  output  1  to array Write
MemRefresh  output  1  to array Refresh
MemDataOut  output  DATA_WIDTH  write data toward the array's bidirectional data pins
MemDataOE  output  1  data driver enable; drive the bus only when 1
MemDataIn  input  DATA_WIDTH  array data bus sampled on reads
RefreshOverrun  output  1  sticky: refresh period expired while one was still pending

Behaviour:
- Reset (async, Reset=1): state IDLE; all outputs 0; refresh counter 0; pending 0; latched address/data 0. Reset mid-operation aborts the access or refresh immediately, and MemEnable, MemDataOE and MemRefresh drop without waiting for a clock edge.
- All Mem* outputs, RspValid and RspData are registered (Moore); ReqReady is combinational.
- ReqReady = (state==IDLE) && !RefreshPending. A transfer occurs on a rising edge with ReqValid&&ReqReady; ReqAddr, ReqWData and ReqWrite are latched at that edge.
- Refresh timer:
  - Free-running counter 0..REFRESH_INTERVAL-1; it keeps counting in every state.
  - On wrap it sets RefreshPending.
  - If RefreshPending is already 1 at wrap, RefreshOverrun sets and stays set until Reset.
- States:
  - IDLE: Mem* outputs 0. RefreshPending has priority: go to REFRESH, ignoring ReqValid in the same cycle (ReqReady is already 0). Otherwise, on a transfer, go to WRITE or READ.
  - WRITE: exactly 1 cycle. MemEnable=MemWrite=MemDataOE=1, MemAddress/MemDataOut = latched values. Then IDLE. No response is generated.
  - READ: READ_LATENCY cycles. MemEnable=MemRead=1, MemAddress=latched address. MemDataIn is captured at the edge ending the last READ cycle. Next state IDLE, and in that cycle RspValid=1 and RspData=captured data for exactly 1 cycle.
  - REFRESH: REFRESH_CYCLES cycles, MemEnable=MemRefresh=1. RefreshPending clears on entry. Then IDLE.
- Simultaneous timer wrap and request acceptance in the same IDLE cycle: the request is accepted; the refresh runs after that access completes.
- Back-to-back: minimum spacing between accepted requests is 2 cycles for writes and READ_LATENCY+1 cycles for reads.
- RspData holds its last value when RspValid=0.
- MemRead, MemWrite and MemRefresh are mutually exclusive in every cycle.

Decomposition:
- Package sdr_qsram_pkg: state enum (IDLE, WRITE, READ, REFRESH), and a function giving the counter width for a count value (clog2).
- Sub-module sdr_qsram_refresh_timer: counter, RefreshPending set/clear, RefreshOverrun.
- The FSM and datapath latches live in sdr_qsram_ctrl.

Test Plan:
- Reset held 3 cycles, then released -> every output is 0 and ReqReady=1 on the first cycle after release.
- Write addr=4'h3, data=8'hA5 -> next cycle MemEnable=MemWrite=MemDataOE=1, MemAddress=3, MemDataOut=A5 for exactly 1 cycle; ReqReady=0 that cycle.
- Read addr=4'h3 with the model returning 8'h5A -> MemRead=1 for 2 cycles, then RspValid=1 and RspData=5A for 1 cycle; request-to-response is 3 cycles.
- Idle for 64 cycles after reset -> MemRefresh=1 for 2 cycles starting 1 cycle after the wrap; ReqReady=0 from the wrap through the end of refresh.
- ReqValid held high continuously across a wrap -> the in-flight access completes, then refresh runs, then the pending request is accepted; MemRead, MemWrite and MemRefresh never overlap.
- Reset asserted mid-READ -> MemEnable=0 before the next edge; no RspValid; RefreshOverrun=0 afterwards.
